proc_hier_wrap: RTL and testbench

Top-level processor hierarchy shell: conditions the board reset, instantiates the pipelined 16-bit core (`proc`), and exposes a flattened per-cycle observation bus plus performance counters for trace generation and end-of-run statistics. It sits directly under the simulation bench and has no memory ports; all memories and caches live inside the core.

---
 rtl/proc_hier_wrap_pkg.sv | 44 ++++
 rtl/proc.sv | 156 +++++++++++++++
 rtl/rst_sync.sv | 21 ++
 rtl/proc_hier_wrap.sv | 145 ++++++++++++++
 tb/tb_proc_hier_wrap.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/proc_hier_wrap_pkg.sv
// Shared types and constants for the processor hierarchy shell and its core.
// Also holds the boot program ROM contents of the core.
package proc_hier_wrap_pkg;

    localparam int CNT_W_DEF  = 32;
    localparam int IMEM_DEPTH = 32;
    localparam int DMEM_DEPTH = 16;

    typedef logic [15:0] word_t;
    typedef logic [2:0]  reg_idx_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADDI = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_HALT = 4'hF
    } opcode_e;

    // Contents of the MEM/WB pipeline register; also the core's observation bus.
    typedef struct packed {
        logic     reg_write;
        reg_idx_t rd;
        word_t    wdata;
        logic     mem_read;
        logic     mem_write;
        word_t    addr;
        word_t    sdata;
        logic     halt;
        logic     illegal;
    } mem_wb_t;

    // Boot program: addi r1,r0,5; st r1,[r0+2]; ld r2,[r0+2]; nop x14; halt r3,7
    function automatic word_t boot_rom(input logic [4:0] addr);
        case (addr)
            5'd0:    boot_rom = 16'h1205;
            5'd1:    boot_rom = 16'h3202;
            5'd2:    boot_rom = 16'h2402;
            5'd17:   boot_rom = 16'hF607;
            default: boot_rom = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/proc.sv
// Three-stage 16-bit core (fetch, decode/execute, MEM/WB) with ROM program,
// forwarding from MEM/WB, and valid-bit cache models producing hit/req strobes.
module proc
    import proc_hier_wrap_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    output logic     err_o,
    output word_t    pc_o,
    output word_t    inst_o,
    output logic     reg_write_o,
    output reg_idx_t write_reg_o,
    output word_t    write_data_o,
    output logic     mem_read_o,
    output logic     mem_write_o,
    output word_t    mem_addr_o,
    output word_t    mem_data_in_o,
    output word_t    mem_data_out_o,
    output logic     halt_o,
    output logic     icache_req_o,
    output logic     icache_hit_o,
    output logic     dcache_req_o,
    output logic     dcache_hit_o
);

    word_t   pc_q, pc_d;
    word_t   inst_q, inst_d;
    mem_wb_t mw_q, mw_d;
    logic    stop_q, stop_d;
    logic    err_q, err_d;
    logic [IMEM_DEPTH/2-1:0] ivalid_q, ivalid_d;
    logic [DMEM_DEPTH/2-1:0] dvalid_q, dvalid_d;

    word_t rf   [8];
    word_t dmem [DMEM_DEPTH];

    logic [3:0] opcode;
    reg_idx_t   rd, rs;
    word_t      imm, rs_val, rd_val, dmem_rdata, wb_data;
    logic       dec_halt, fetch_en, dcache_req;

    assign opcode     = inst_q[15:12];
    assign rd         = inst_q[11:9];
    assign rs         = inst_q[8:6];
    assign imm        = {{10{inst_q[5]}}, inst_q[5:0]};
    assign dec_halt   = (opcode == OP_HALT);
    assign fetch_en   = !stop_q && !dec_halt;
    assign dmem_rdata = dmem[mw_q.addr[3:0]];
    assign wb_data    = mw_q.mem_read ? dmem_rdata : mw_q.wdata;
    assign dcache_req = mw_q.mem_read | mw_q.mem_write;

    // Register read with bypass from the instruction currently in MEM/WB.
    function automatic word_t read_reg(input reg_idx_t idx);
        if (idx == 3'd0)
            read_reg = '0;
        else if (mw_q.reg_write && mw_q.rd == idx)
            read_reg = wb_data;
        else
            read_reg = rf[idx];
    endfunction

    assign rs_val = read_reg(rs);
    assign rd_val = read_reg(rd);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pc_d     = pc_q;
        inst_d   = 16'h0000;
        stop_d   = stop_q | dec_halt;
        mw_d     = '0;
        err_d    = err_q | mw_q.illegal;
        ivalid_d = ivalid_q;
        dvalid_d = dvalid_q;

        if (fetch_en) begin
            inst_d                = boot_rom(pc_q[4:0]);
            pc_d                  = pc_q + 16'd1;
            ivalid_d[pc_q[4:1]]   = 1'b1;
        end
        if (dcache_req)
            dvalid_d[mw_q.addr[3:1]] = 1'b1;

        case (opcode)
            OP_NOP: ;
            OP_ADDI: begin
                mw_d.reg_write = (rd != 3'd0);
                mw_d.rd        = rd;
                mw_d.wdata     = rs_val + imm;
            end
            OP_LD: begin
                mw_d.reg_write = (rd != 3'd0);
                mw_d.rd        = rd;
                mw_d.mem_read  = 1'b1;
                mw_d.addr      = rs_val + imm;
            end
            OP_ST: begin
                mw_d.mem_write = 1'b1;
                mw_d.addr      = rs_val + imm;
                mw_d.sdata     = rd_val;
            end
            OP_HALT: begin
                mw_d.halt      = 1'b1;
                mw_d.reg_write = (rd != 3'd0);
                mw_d.rd        = rd;
                mw_d.wdata     = imm;
            end
            default: mw_d.illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q     <= '0;
            inst_q   <= '0;
            mw_q     <= '0;
            stop_q   <= 1'b0;
            err_q    <= 1'b0;
            ivalid_q <= '0;
            dvalid_q <= '0;
        end else begin
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            mw_q     <= mw_d;
            stop_q   <= stop_d;
            err_q    <= err_d;
            ivalid_q <= ivalid_d;
            dvalid_q <= dvalid_d;
        end
    end

    // NOTE: storage arrays are not reset; software writes before it reads.
    always_ff @(posedge clk_i) begin
        if (mw_q.reg_write)
            rf[mw_q.rd] <= wb_data;
        if (mw_q.mem_write)
            dmem[mw_q.addr[3:0]] <= mw_q.sdata;
    end

    assign err_o          = err_q;
    assign pc_o           = pc_q;
    assign inst_o         = inst_q;
    assign reg_write_o    = mw_q.reg_write;
    assign write_reg_o    = mw_q.rd;
    assign write_data_o   = wb_data;
    assign mem_read_o     = mw_q.mem_read;
    assign mem_write_o    = mw_q.mem_write;
    assign mem_addr_o     = mw_q.addr;
    assign mem_data_in_o  = mw_q.sdata;
    assign mem_data_out_o = mw_q.mem_read ? dmem_rdata : '0;
    assign halt_o         = mw_q.halt;
    assign icache_req_o   = fetch_en;
    assign icache_hit_o   = fetch_en & ivalid_q[pc_q[4:1]];
    assign dcache_req_o   = dcache_req;
    assign dcache_hit_o   = dcache_req & dvalid_q[mw_q.addr[3:1]];

endmodule

// File: rtl/rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the 2nd clean edge.
module rst_sync (
    input  logic clk_i,
    input  logic rst_ni,
    output logic core_rst_o
);

    logic [1:0] sync_q;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign core_rst_o = ~sync_q[1];

endmodule

// File: rtl/proc_hier_wrap.sv
// Processor hierarchy shell: reset conditioning, core instance, gated trace bus
// and performance counters that freeze once a Halt has retired.
module proc_hier_wrap
    import proc_hier_wrap_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             core_rst,
    output logic             halted,
    output logic             err,
    output word_t            pc,
    output word_t            inst,
    output logic             reg_write,
    output reg_idx_t         write_reg,
    output word_t            write_data,
    output logic             mem_read,
    output logic             mem_write,
    output word_t            mem_addr,
    output word_t            mem_data_in,
    output word_t            mem_data_out,
    output logic             halt,
    output logic             icache_req,
    output logic             icache_hit,
    output logic             dcache_req,
    output logic             dcache_hit,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] icache_req_count,
    output logic [CNT_W-1:0] icache_hit_count,
    output logic [CNT_W-1:0] dcache_req_count,
    output logic [CNT_W-1:0] dcache_hit_count
);

    word_t    c_pc, c_inst, c_wdata, c_addr, c_din, c_dout;
    reg_idx_t c_wreg;
    logic     c_rw, c_mr, c_mw, c_halt, c_ireq, c_ihit, c_dreq, c_dhit;

    rst_sync u_rst_sync (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .core_rst_o (core_rst)
    );

    proc u_proc (
        .clk_i          (clk),
        .rst_i          (core_rst),
        .err_o          (err),
        .pc_o           (c_pc),
        .inst_o         (c_inst),
        .reg_write_o    (c_rw),
        .write_reg_o    (c_wreg),
        .write_data_o   (c_wdata),
        .mem_read_o     (c_mr),
        .mem_write_o    (c_mw),
        .mem_addr_o     (c_addr),
        .mem_data_in_o  (c_din),
        .mem_data_out_o (c_dout),
        .halt_o         (c_halt),
        .icache_req_o   (c_ireq),
        .icache_hit_o   (c_ihit),
        .dcache_req_o   (c_dreq),
        .dcache_hit_o   (c_dhit)
    );

    // Trace bus reads as all-zero while the core is held in reset.
    assign pc           = core_rst ? '0 : c_pc;
    assign inst         = core_rst ? '0 : c_inst;
    assign reg_write    = ~core_rst & c_rw;
    assign write_reg    = core_rst ? '0 : c_wreg;
    assign write_data   = core_rst ? '0 : c_wdata;
    assign mem_read     = ~core_rst & c_mr;
    assign mem_write    = ~core_rst & c_mw;
    assign mem_addr     = core_rst ? '0 : c_addr;
    assign mem_data_in  = core_rst ? '0 : c_din;
    assign mem_data_out = core_rst ? '0 : c_dout;
    assign halt         = ~core_rst & c_halt;
    assign icache_req   = ~core_rst & c_ireq;
    assign icache_hit   = ~core_rst & c_ihit;
    assign dcache_req   = ~core_rst & c_dreq;
    assign dcache_hit   = ~core_rst & c_dhit;

    logic [CNT_W-1:0] cyc_q, cyc_d, ins_q, ins_d, ireq_q, ireq_d;
    logic [CNT_W-1:0] ihit_q, ihit_d, dreq_q, dreq_d, dhit_q, dhit_d;
    logic             halted_q, halted_d;

    always_comb begin
        cyc_d    = cyc_q;
        ins_d    = ins_q;
        ireq_d   = ireq_q;
        ihit_d   = ihit_q;
        dreq_d   = dreq_q;
        dhit_d   = dhit_q;
        halted_d = halted_q;
        if (!halted_q) begin
            cyc_d = cyc_q + CNT_W'(1);
            // Coincident retire events still count as one instruction.
            if (c_halt | c_rw | c_mw) ins_d  = ins_q + CNT_W'(1);
            if (c_ireq)               ireq_d = ireq_q + CNT_W'(1);
            if (c_ihit)               ihit_d = ihit_q + CNT_W'(1);
            if (c_dreq)               dreq_d = dreq_q + CNT_W'(1);
            if (c_dhit)               dhit_d = dhit_q + CNT_W'(1);
            halted_d = c_halt;
        end
    end

    // rst_n clears at once; the synchronized core_rst keeps them cleared until release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q    <= '0;
            ins_q    <= '0;
            ireq_q   <= '0;
            ihit_q   <= '0;
            dreq_q   <= '0;
            dhit_q   <= '0;
            halted_q <= 1'b0;
        end else if (core_rst) begin
            cyc_q    <= '0;
            ins_q    <= '0;
            ireq_q   <= '0;
            ihit_q   <= '0;
            dreq_q   <= '0;
            dhit_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            cyc_q    <= cyc_d;
            ins_q    <= ins_d;
            ireq_q   <= ireq_d;
            ihit_q   <= ihit_d;
            dreq_q   <= dreq_d;
            dhit_q   <= dhit_d;
            halted_q <= halted_d;
        end
    end

    assign cycle_count      = cyc_q;
    assign inst_count       = ins_q;
    assign icache_req_count = ireq_q;
    assign icache_hit_count = ihit_q;
    assign dcache_req_count = dreq_q;
    assign dcache_hit_count = dhit_q;
    assign halted           = halted_q;

endmodule

// File: tb/tb_proc_hier_wrap.sv
// Directed bench for proc_hier_wrap: a 32-bit-counter instance plus a 4-bit-counter
// instance running the same boot program from the same clock and reset.
module tb_proc_hier_wrap;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    logic        core_rst, halted, err, reg_write, mem_read, mem_write, halt;
    logic        icache_req, icache_hit, dcache_req, dcache_hit;
    logic [15:0] pc, inst, write_data, mem_addr, mem_data_in, mem_data_out;
    logic [2:0]  write_reg;
    logic [31:0] cycle_count, inst_count, icache_req_count, icache_hit_count;
    logic [31:0] dcache_req_count, dcache_hit_count;

    logic        s_core_rst, s_halted, s_err, s_reg_write, s_mem_read, s_mem_write, s_halt;
    logic        s_icache_req, s_icache_hit, s_dcache_req, s_dcache_hit;
    logic [15:0] s_pc, s_inst, s_write_data, s_mem_addr, s_mem_data_in, s_mem_data_out;
    logic [2:0]  s_write_reg;
    logic [3:0]  s_cycle_count, s_inst_count, s_icache_req_count, s_icache_hit_count;
    logic [3:0]  s_dcache_req_count, s_dcache_hit_count;

    proc_hier_wrap #(.CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .core_rst(core_rst), .halted(halted), .err(err),
        .pc(pc), .inst(inst), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .halt(halt), .icache_req(icache_req), .icache_hit(icache_hit),
        .dcache_req(dcache_req), .dcache_hit(dcache_hit),
        .cycle_count(cycle_count), .inst_count(inst_count),
        .icache_req_count(icache_req_count), .icache_hit_count(icache_hit_count),
        .dcache_req_count(dcache_req_count), .dcache_hit_count(dcache_hit_count)
    );

    proc_hier_wrap #(.CNT_W(4)) u_small (
        .clk(clk), .rst_n(rst_n), .core_rst(s_core_rst), .halted(s_halted), .err(s_err),
        .pc(s_pc), .inst(s_inst), .reg_write(s_reg_write), .write_reg(s_write_reg),
        .write_data(s_write_data), .mem_read(s_mem_read), .mem_write(s_mem_write),
        .mem_addr(s_mem_addr), .mem_data_in(s_mem_data_in), .mem_data_out(s_mem_data_out),
        .halt(s_halt), .icache_req(s_icache_req), .icache_hit(s_icache_hit),
        .dcache_req(s_dcache_req), .dcache_hit(s_dcache_hit),
        .cycle_count(s_cycle_count), .inst_count(s_inst_count),
        .icache_req_count(s_icache_req_count), .icache_hit_count(s_icache_hit_count),
        .dcache_req_count(s_dcache_req_count), .dcache_hit_count(s_dcache_hit_count)
    );

    logic obs_any, cnt_any, s_cnt_any;
    assign obs_any = |{pc, inst, reg_write, write_reg, write_data, mem_read, mem_write,
                       mem_addr, mem_data_in, mem_data_out, halt, icache_req, icache_hit,
                       dcache_req, dcache_hit};
    assign cnt_any = |{cycle_count, inst_count, icache_req_count, icache_hit_count,
                       dcache_req_count, dcache_hit_count};
    assign s_cnt_any = |{s_cycle_count, s_inst_count, s_icache_req_count,
                         s_icache_hit_count, s_dcache_req_count, s_dcache_hit_count};

    // Advance n clock cycles, ending mid-cycle on the falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(5);
        n_cmp++; if (core_rst !== 1'b1) begin n_err++; $display("FAIL rst_hold_core_rst: got %b want 1", core_rst); end
        n_cmp++; if (obs_any !== 1'b0) begin n_err++; $display("FAIL rst_hold_obs: got %b want 0", obs_any); end
        n_cmp++; if ({cnt_any, halted} !== 2'b00) begin n_err++; $display("FAIL rst_hold_cnt: got %b want 00", {cnt_any, halted}); end
        rst_n = 1'b1;
        step(1);
        n_cmp++; if (core_rst !== 1'b1) begin n_err++; $display("FAIL rst_edge1_core_rst: got %b want 1", core_rst); end
        n_cmp++; if (obs_any !== 1'b0) begin n_err++; $display("FAIL rst_edge1_obs: got %b want 0", obs_any); end
        step(1);
        n_cmp++; if (core_rst !== 1'b0) begin n_err++; $display("FAIL rst_edge2_core_rst: got %b want 0", core_rst); end
        n_cmp++; if (cycle_count !== 32'd0) begin n_err++; $display("FAIL rst_edge2_cycles: got %0d want 0", cycle_count); end
    endtask

    task automatic test_trace;
        // cycle 1: first fetch, cold icache
        n_cmp++; if ({pc, icache_req, icache_hit} !== {16'h0000, 1'b1, 1'b0}) begin n_err++;
            $display("FAIL c1_fetch: got pc=%h req=%b hit=%b want pc=0000 req=1 hit=0", pc, icache_req, icache_hit); end
        step(1);
        n_cmp++; if ({pc, inst, icache_hit} !== {16'h0001, 16'h1205, 1'b1}) begin n_err++;
            $display("FAIL c2_fetch: got pc=%h inst=%h hit=%b want pc=0001 inst=1205 hit=1", pc, inst, icache_hit); end
        step(1);
        n_cmp++; if ({reg_write, write_reg, write_data} !== {1'b1, 3'd1, 16'h0005}) begin n_err++;
            $display("FAIL c3_reg_r1: got we=%b r%0d=%h want we=1 r1=0005", reg_write, write_reg, write_data); end
        step(1);
        n_cmp++; if ({mem_write, mem_addr, mem_data_in, dcache_req, dcache_hit} !== {1'b1, 16'h0002, 16'h0005, 1'b1, 1'b0}) begin n_err++;
            $display("FAIL c4_store: got we=%b addr=%h data=%h dreq=%b dhit=%b want 1 0002 0005 1 0", mem_write, mem_addr, mem_data_in, dcache_req, dcache_hit); end
        step(1);
        n_cmp++; if ({mem_read, mem_addr, mem_data_out, dcache_hit} !== {1'b1, 16'h0002, 16'h0005, 1'b1}) begin n_err++;
            $display("FAIL c5_load: got re=%b addr=%h data=%h dhit=%b want 1 0002 0005 1", mem_read, mem_addr, mem_data_out, dcache_hit); end
        n_cmp++; if ({reg_write, write_reg, write_data} !== {1'b1, 3'd2, 16'h0005}) begin n_err++;
            $display("FAIL c5_reg_r2: got we=%b r%0d=%h want we=1 r2=0005", reg_write, write_reg, write_data); end
        n_cmp++; if ({cycle_count, inst_count} !== {32'd4, 32'd2}) begin n_err++;
            $display("FAIL c5_counts: got cyc=%0d ins=%0d want cyc=4 ins=2", cycle_count, inst_count); end
    endtask

    task automatic test_coincident;
        step(15);
        n_cmp++; if ({halt, reg_write, write_reg, write_data} !== {1'b1, 1'b1, 3'd3, 16'h0007}) begin n_err++;
            $display("FAIL c20_halt_reg: got halt=%b we=%b r%0d=%h want 1 1 r3=0007", halt, reg_write, write_reg, write_data); end
        n_cmp++; if ({cycle_count, inst_count, halted} !== {32'd19, 32'd3, 1'b0}) begin n_err++;
            $display("FAIL c20_counts: got cyc=%0d ins=%0d halted=%b want 19 3 0", cycle_count, inst_count, halted); end
        step(1);
        n_cmp++; if ({cycle_count, inst_count, halted} !== {32'd20, 32'd4, 1'b1}) begin n_err++;
            $display("FAIL c21_after_halt: got cyc=%0d ins=%0d halted=%b want 20 4 1", cycle_count, inst_count, halted); end
    endtask

    task automatic test_halt_freeze;
        step(10);
        n_cmp++; if ({cycle_count, inst_count, halted} !== {32'd20, 32'd4, 1'b1}) begin n_err++;
            $display("FAIL freeze_counts: got cyc=%0d ins=%0d halted=%b want 20 4 1", cycle_count, inst_count, halted); end
        n_cmp++; if ({icache_req_count, icache_hit_count} !== {32'd18, 32'd9}) begin n_err++;
            $display("FAIL freeze_icache: got req=%0d hit=%0d want 18 9", icache_req_count, icache_hit_count); end
        n_cmp++; if ({dcache_req_count, dcache_hit_count} !== {32'd2, 32'd1}) begin n_err++;
            $display("FAIL freeze_dcache: got req=%0d hit=%0d want 2 1", dcache_req_count, dcache_hit_count); end
        n_cmp++; if ({pc, inst, halt, err} !== {16'd18, 16'h0000, 1'b0, 1'b0}) begin n_err++;
            $display("FAIL freeze_obs: got pc=%0d inst=%h halt=%b err=%b want 18 0000 0 0", pc, inst, halt, err); end
    endtask

    task automatic test_wrap;
        n_cmp++; if ({s_cycle_count, s_inst_count, s_halted} !== {4'd4, 4'd4, 1'b1}) begin n_err++;
            $display("FAIL wrap_counts: got cyc=%0d ins=%0d halted=%b want 4 4 1", s_cycle_count, s_inst_count, s_halted); end
        n_cmp++; if ({s_icache_req_count, s_icache_hit_count} !== {4'd2, 4'd9}) begin n_err++;
            $display("FAIL wrap_icache: got req=%0d hit=%0d want 2 9", s_icache_req_count, s_icache_hit_count); end
    endtask

    task automatic test_async_reset;
        int waited;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({core_rst, s_core_rst} !== 2'b11) begin n_err++;
            $display("FAIL async_core_rst: got %b want 11", {core_rst, s_core_rst}); end
        n_cmp++; if ({cnt_any, s_cnt_any, halted, s_halted} !== 4'b0000) begin n_err++;
            $display("FAIL async_counters: got %b want 0000", {cnt_any, s_cnt_any, halted, s_halted}); end
        n_cmp++; if (obs_any !== 1'b0) begin n_err++; $display("FAIL async_obs: got %b want 0", obs_any); end
        step(3);
        rst_n = 1'b1;
        waited = 0;
        while (halted !== 1'b1 && waited < 60) begin
            step(1);
            waited++;
        end
        n_cmp++; if (waited != 22) begin n_err++; $display("FAIL restart_halt_latency: got %0d cycles want 22", waited); end
        n_cmp++; if ({cycle_count, inst_count, s_cycle_count} !== {32'd20, 32'd4, 4'd4}) begin n_err++;
            $display("FAIL restart_counts: got cyc=%0d ins=%0d small_cyc=%0d want 20 4 4", cycle_count, inst_count, s_cycle_count); end
    endtask

    initial begin
        test_reset();
        test_trace();
        test_coincident();
        test_halt_freeze();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
